// File: rtl/p405s_lwb_stage.sv
// Load-writeback (LWB) stage: tracks one outstanding data-cache load miss, steers the returned line-fill data to the GPR file and stalls WB/EXE on conflicts.
// Optional miss-timeout counter and lwbTimeout port are built only when P405S_LWB_TIMEOUT_EN is defined.
module p405s_lwb_stage (
    input  logic       CB,
    input  logic       sysResetN,
    input  logic       wbFull,
    input  logic       wbLoad,
    input  logic       wbLpWrEn,
    input  logic [0:4] wbRT,
    input  logic       wbClearOrFlush,
    input  logic       dcuLdMiss,
    input  logic       dcuLdDataValid,
    input  logic       lwbCancel,
    input  logic [0:4] exeRA,
    input  logic [0:4] exeRB,
    output logic       lwbE1,
    output logic       loadSteerMuxSel,
    output logic       lwbFull,
    output logic [0:4] lwbRT,
    output logic       lwbRpWrEn,
    output logic       lwbLpWrEn,
    output logic       wbHold,
`ifdef P405S_LWB_TIMEOUT_EN
    output logic       lwbTimeout,
`endif
    output logic       lwbDepHit
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        DRAIN = 2'b10
    } lwbState_t;

    lwbState_t  state;
    lwbState_t  nextState;
    logic       newMiss;
    logic       captureEn;
    logic       steerSel;
    logic       rpWrEn;
    logic       holdReq;
    logic       lpWrEnQ;
    logic [0:4] rtQ;

    assign newMiss = wbFull & wbLoad & dcuLdMiss & ~wbClearOrFlush;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        nextState = IDLE;
        captureEn = 1'b0;
        steerSel  = 1'b0;
        rpWrEn    = 1'b0;
        holdReq   = 1'b0;
        case (state)
            PEND: begin
                if (dcuLdDataValid) begin
                    // Data return completes the old miss; a cancelled miss still consumes its data but writes nothing.
                    steerSel  = 1'b1;
                    rpWrEn    = ~lwbCancel;
                    holdReq   = wbFull & wbLoad;
                    captureEn = newMiss;
                    nextState = newMiss ? PEND : IDLE;
                end else begin
                    holdReq   = newMiss;
                    nextState = lwbCancel ? DRAIN : PEND;
                end
            end
            DRAIN: begin
                holdReq   = newMiss;
                nextState = dcuLdDataValid ? IDLE : DRAIN;
            end
            default: begin
                // Encoding 11 is treated as IDLE; lwbCancel is ignored here.
                captureEn = newMiss;
                nextState = newMiss ? PEND : IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CB or negedge sysResetN) begin
        if (!sysResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CB or negedge sysResetN) begin
        if (!sysResetN) begin
            rtQ     <= '0;
            lpWrEnQ <= 1'b0;
        end else if (captureEn) begin
            rtQ     <= wbRT;
            lpWrEnQ <= wbLpWrEn;
        end
    end

    // Combinational outputs are gated by reset so they read 0 the moment reset asserts.
    assign lwbE1           = sysResetN & captureEn;
    assign loadSteerMuxSel = sysResetN & steerSel;
    assign lwbRpWrEn       = sysResetN & rpWrEn;
    assign lwbLpWrEn       = sysResetN & rpWrEn & lpWrEnQ;
    assign wbHold          = sysResetN & holdReq;
    assign lwbFull         = sysResetN & (state == PEND);
    assign lwbRT           = rtQ;
    assign lwbDepHit       = lwbFull & ((exeRA == rtQ) | (exeRB == rtQ));

`ifdef P405S_LWB_TIMEOUT_EN
    logic [7:0] waitCount;
    logic       waitStart;

    // A fresh capture in PEND restarts the count just like entry from IDLE.
    assign waitStart = ((nextState == PEND) && ((state != PEND) || captureEn)) ||
                       ((nextState == DRAIN) && (state != DRAIN));

    always_ff @(posedge CB or negedge sysResetN) begin
        if (!sysResetN) begin
            waitCount <= 8'd0;
        end else if ((nextState == IDLE) || waitStart) begin
            waitCount <= 8'd0;
        end else if (waitCount != 8'hFF) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    assign lwbTimeout = sysResetN & (waitCount == 8'hFF);
`endif

endmodule

// File: tb/tb_p405s_lwb_stage.sv
// Self-checking bench for p405s_lwb_stage: directed scenarios then randomized traffic against a behavioural miss-tracking model.
// Define P405S_LWB_TIMEOUT_EN for both files to also exercise the timeout counter.
module tb_p405s_lwb_stage;

    logic       CB = 1'b0;
    logic       sysResetN;
    logic       wbFull, wbLoad, wbLpWrEn, wbClearOrFlush;
    logic [0:4] wbRT, exeRA, exeRB;
    logic       dcuLdMiss, dcuLdDataValid, lwbCancel;
    logic       lwbE1, loadSteerMuxSel, lwbFull, lwbRpWrEn, lwbLpWrEn, wbHold, lwbDepHit;
    logic [0:4] lwbRT;
`ifdef P405S_LWB_TIMEOUT_EN
    logic       lwbTimeout;
`endif

    always #5 CB = ~CB;

    p405s_lwb_stage dut (
        .CB(CB), .sysResetN(sysResetN),
        .wbFull(wbFull), .wbLoad(wbLoad), .wbLpWrEn(wbLpWrEn), .wbRT(wbRT),
        .wbClearOrFlush(wbClearOrFlush), .dcuLdMiss(dcuLdMiss),
        .dcuLdDataValid(dcuLdDataValid), .lwbCancel(lwbCancel),
        .exeRA(exeRA), .exeRB(exeRB),
        .lwbE1(lwbE1), .loadSteerMuxSel(loadSteerMuxSel), .lwbFull(lwbFull),
        .lwbRT(lwbRT), .lwbRpWrEn(lwbRpWrEn), .lwbLpWrEn(lwbLpWrEn),
        .wbHold(wbHold),
`ifdef P405S_LWB_TIMEOUT_EN
        .lwbTimeout(lwbTimeout),
`endif
        .lwbDepHit(lwbDepHit)
    );

    int checkCount = 0;
    int errorCount = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: is a miss outstanding, is a cancelled miss still owed its data, what was captured.
    bit         missOutstanding;
    bit         awaitingCancelledData;
    logic [0:4] heldRT;
    bit         heldLp;
    int         waitCycles;

    task automatic modelReset();
        missOutstanding       = 0;
        awaitingCancelledData = 0;
        heldRT                = '0;
        heldLp                = 0;
        waitCycles            = 0;
    endtask

    function automatic bit isNewMiss();
        return wbFull && wbLoad && dcuLdMiss && !wbClearOrFlush;
    endfunction

    task automatic checkOutputs();
        bit expE1, expSteer, expRp, expHold;
        expE1 = 0; expSteer = 0; expRp = 0; expHold = 0;
        if (missOutstanding) begin
            if (dcuLdDataValid) begin
                expSteer = 1;
                expRp    = !lwbCancel;
                expHold  = wbFull && wbLoad;
                expE1    = isNewMiss();
            end else begin
                expHold = isNewMiss();
            end
        end else if (awaitingCancelledData) begin
            expHold = isNewMiss();
        end else begin
            expE1 = isNewMiss();
        end
        check("lwbE1", lwbE1, expE1);
        check("loadSteerMuxSel", loadSteerMuxSel, expSteer);
        check("lwbRpWrEn", lwbRpWrEn, expRp);
        check("lwbLpWrEn", lwbLpWrEn, expRp && heldLp);
        check("wbHold", wbHold, expHold);
        check("lwbFull", lwbFull, missOutstanding);
        check("lwbRT", lwbRT, heldRT);
        check("lwbDepHit", lwbDepHit, missOutstanding && (exeRA == heldRT || exeRB == heldRT));
`ifdef P405S_LWB_TIMEOUT_EN
        check("lwbTimeout", lwbTimeout, (missOutstanding || awaitingCancelledData) && waitCycles >= 255);
`endif
    endtask

    task automatic modelClock();
        bit restart;
        restart = 0;
        if (missOutstanding) begin
            if (dcuLdDataValid) begin
                missOutstanding = isNewMiss();
                restart         = isNewMiss();
            end else if (lwbCancel) begin
                missOutstanding       = 0;
                awaitingCancelledData = 1;
                restart               = 1;
            end
        end else if (awaitingCancelledData) begin
            if (dcuLdDataValid) awaitingCancelledData = 0;
        end else if (isNewMiss()) begin
            missOutstanding = 1;
            restart         = 1;
        end
        if (restart && missOutstanding) begin
            heldRT = wbRT;
            heldLp = wbLpWrEn;
        end
        if (restart || !(missOutstanding || awaitingCancelledData)) waitCycles = 0;
        else if (waitCycles < 255) waitCycles++;
    endtask

    task automatic drive(input bit full, input bit load, input bit lp, input logic [0:4] rt,
                         input bit cof, input bit miss, input bit dv, input bit cancel,
                         input logic [0:4] ra, input logic [0:4] rb);
        wbFull = full; wbLoad = load; wbLpWrEn = lp; wbRT = rt; wbClearOrFlush = cof;
        dcuLdMiss = miss; dcuLdDataValid = dv; lwbCancel = cancel; exeRA = ra; exeRB = rb;
    endtask

    // One cycle: drive at the falling edge, check just after, advance the model on the rising edge.
    task automatic stepCycle(input bit full, input bit load, input bit lp, input logic [0:4] rt,
                             input bit cof, input bit miss, input bit dv, input bit cancel,
                             input logic [0:4] ra, input logic [0:4] rb);
        @(negedge CB);
        drive(full, load, lp, rt, cof, miss, dv, cancel, ra, rb);
        #1;
        checkOutputs();
        @(posedge CB);
        modelClock();
        #1;
    endtask

    task automatic quiet();
        stepCycle(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd31, 5'd31);
    endtask

    // Asserts reset away from the clock edge with a miss and data on the inputs; outputs must drop at once.
    task automatic resetPulse();
        @(negedge CB);
        drive(1, 1, 1, 5'd3, 0, 1, 1, 0, 5'd0, 5'd0);
        #1;
        sysResetN = 1'b0;
        #1;
        check("rst.lwbE1", lwbE1, 0);
        check("rst.loadSteerMuxSel", loadSteerMuxSel, 0);
        check("rst.lwbFull", lwbFull, 0);
        check("rst.lwbRT", lwbRT, 0);
        check("rst.lwbRpWrEn", lwbRpWrEn, 0);
        check("rst.lwbLpWrEn", lwbLpWrEn, 0);
        check("rst.wbHold", wbHold, 0);
        check("rst.lwbDepHit", lwbDepHit, 0);
        modelReset();
        @(negedge CB);
        drive(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd31, 5'd31);
        #1;
        sysResetN = 1'b1;
    endtask

    initial begin
        modelReset();
        drive(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd31, 5'd31);
        sysResetN = 1'b0;
        #12;
        checkOutputs();
        @(negedge CB);
        sysResetN = 1'b1;

        // New miss with rt=5 captures and goes pending; data then completes it.
        stepCycle(1, 1, 1, 5'd5, 0, 1, 0, 0, 5'd31, 5'd31);
        check("dir.fullAfterMiss", lwbFull, 1);
        check("dir.rtAfterMiss", lwbRT, 5);
        stepCycle(0, 0, 0, 5'd0, 0, 0, 1, 0, 5'd31, 5'd31);
        check("dir.fullAfterData", lwbFull, 0);

        // Same-cycle return and new miss: old one completes, rt=9 is recaptured, still pending.
        stepCycle(1, 1, 0, 5'd5, 0, 1, 0, 0, 5'd31, 5'd31);
        stepCycle(1, 1, 1, 5'd9, 0, 1, 1, 0, 5'd31, 5'd31);
        check("dir.recaptureRT", lwbRT, 9);
        check("dir.recaptureFull", lwbFull, 1);

        // Cancel, data three cycles later; a new miss in the drain window is held off.
        stepCycle(0, 0, 0, 5'd0, 0, 0, 0, 1, 5'd31, 5'd31);
        quiet();
        stepCycle(1, 1, 0, 5'd12, 0, 1, 0, 0, 5'd31, 5'd31);
        stepCycle(0, 0, 0, 5'd0, 0, 0, 1, 0, 5'd31, 5'd31);
        check("dir.idleAfterDrain", lwbFull, 0);

        // Dependency on rt=7 through exeRB, then reset mid-pend and stray data afterwards.
        stepCycle(1, 1, 1, 5'd7, 0, 1, 0, 0, 5'd31, 5'd31);
        stepCycle(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd2, 5'd7);
        check("dir.depHitRB", lwbDepHit, 1);
        resetPulse();
        stepCycle(0, 0, 0, 5'd0, 0, 0, 1, 0, 5'd0, 5'd0);

`ifdef P405S_LWB_TIMEOUT_EN
        stepCycle(1, 1, 0, 5'd4, 0, 1, 0, 0, 5'd31, 5'd31);
        for (int i = 0; i < 260; i++) quiet();
        check("dir.timeoutSet", lwbTimeout, 1);
        stepCycle(0, 0, 0, 5'd0, 0, 0, 1, 0, 5'd31, 5'd31);
        check("dir.timeoutClear", lwbTimeout, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [0:4] rt, ra, rb;
            if ($urandom_range(399) == 0) begin
                resetPulse();
            end else begin
                rt = 5'($urandom_range(31));
                ra = ($urandom_range(3) == 0) ? heldRT : 5'($urandom_range(31));
                rb = ($urandom_range(3) == 0) ? heldRT : 5'($urandom_range(31));
                stepCycle($urandom_range(9) < 7, $urandom_range(9) < 6, 1'($urandom_range(1)), rt,
                          $urandom_range(9) == 0, $urandom_range(9) < 4, $urandom_range(3) == 0,
                          $urandom_range(11) == 0, ra, rb);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
